score_update_arbiter: RTL and testbench

Arbitrates score-change requests from the two player inputs and a game-clear request into the single shared pair of score registers that feed the display controller's `p1_score_i` / `p2_score_i`. Each accepted request passes through a fixed sequence: grant, update, then hold-off. Simultaneous player requests are resolved round-robin. The block applies saturating arithmetic, detects the winner, and locks the scores until the game is cleared.

---
 rtl/scoreboard_pkg.sv | 36 +++
 rtl/score_rr_arbiter.sv | 22 ++
 rtl/score_update_arbiter.sv | 170 +++++++++++++++++
 tb/tb_score_update_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// Shared scoreboard definitions: FSM state codes, winner codes, player ids
// and the saturating +/-1 step used on score registers.
package scoreboard_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
        ST_UPDATE    = 3'd2,
        ST_LOCKOUT   = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam logic PLAYER_1 = 1'b0;
    localparam logic PLAYER_2 = 1'b1;

    // 9-bit intermediate so an increment at 255 cannot wrap before clamping.
    function automatic logic [7:0] sat_step(input logic [7:0] cur,
                                            input logic       dec,
                                            input logic [7:0] max_score);
        logic [8:0] wide;
        if (dec) begin
            wide = (cur == 8'd0) ? 9'd0 : ({1'b0, cur} - 9'd1);
        end else begin
            wide = {1'b0, cur} + 9'd1;
            if (wide > {1'b0, max_score}) begin
                wide = {1'b0, max_score};
            end
        end
        return wide[7:0];
    endfunction

endpackage

// File: rtl/score_rr_arbiter.sv
// Two-requester round-robin arbiter; the last-grant history lives in the parent.
module score_rr_arbiter
    import scoreboard_pkg::*;
(
    input  logic p1_req_i,
    input  logic p2_req_i,
    input  logic last_grant_i,
    output logic gnt_valid_o,
    output logic gnt_id_o
);

    always_comb begin
        gnt_valid_o = p1_req_i | p2_req_i;
        gnt_id_o    = PLAYER_1;
        if (p1_req_i && p2_req_i) begin
            gnt_id_o = (last_grant_i == PLAYER_1) ? PLAYER_2 : PLAYER_1;
        end else if (p2_req_i) begin
            gnt_id_o = PLAYER_2;
        end
    end

endmodule

// File: rtl/score_update_arbiter.sv
// Serialises player score requests and game clear into the shared score
// registers: grant -> update -> lockout, with saturation and win detection.
module score_update_arbiter
    import scoreboard_pkg::*;
#(
    parameter int unsigned MAX_SCORE      = 99,
    parameter int unsigned WIN_SCORE      = 21,
    parameter int unsigned LOCKOUT_CYCLES = 1_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       p1_req_i,
    input  logic       p1_dec_i,
    input  logic       p2_req_i,
    input  logic       p2_dec_i,
    input  logic       clear_i,
    output logic       p1_ack_o,
    output logic       p2_ack_o,
    output logic [7:0] p1_score_o,
    output logic [7:0] p2_score_o,
    output logic [1:0] winner_o,
    output logic       busy_o,
    output logic [2:0] state_o
);

    localparam int unsigned CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [7:0] MAX_S = 8'(MAX_SCORE);
    localparam logic [8:0] WIN_S = 9'(WIN_SCORE);

    state_e           state_q, state_d;
    logic [7:0]       p1_score_q, p1_score_d;
    logic [7:0]       p2_score_q, p2_score_d;
    logic [7:0]       stage_q, stage_d;
    logic [1:0]       winner_q, winner_d;
    logic             last_grant_q, last_grant_d;
    logic             gnt_id_q, gnt_id_d;
    logic             dec_q, dec_d;
    logic             p1_ack_q, p1_ack_d;
    logic             p2_ack_q, p2_ack_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    logic       arb_valid;
    logic       arb_id;
    logic [7:0] cur_score;
    logic [7:0] oth_score;
    logic       win_hit;

    score_rr_arbiter u_rr_arbiter (
        .p1_req_i     (p1_req_i),
        .p2_req_i     (p2_req_i),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (arb_valid),
        .gnt_id_o     (arb_id)
    );

    assign cur_score = (gnt_id_q == PLAYER_1) ? p1_score_q : p2_score_q;
    assign oth_score = (gnt_id_q == PLAYER_1) ? p2_score_q : p1_score_q;

    // Win is judged on the staged (post-update) value; compare in 9 bits so the lead test never goes negative.
    assign win_hit = (stage_q == MAX_S) ||
                     (({1'b0, stage_q} >= WIN_S) && ({1'b0, stage_q} >= ({1'b0, oth_score} + 9'd2)));

    always_comb begin
        state_d      = state_q;
        p1_score_d   = p1_score_q;
        p2_score_d   = p2_score_q;
        stage_d      = stage_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        dec_d        = dec_q;
        p1_ack_d     = 1'b0;
        p2_ack_d     = 1'b0;
        lock_cnt_d   = lock_cnt_q;

        if (clear_i) begin
            p1_score_d = 8'd0;
            p2_score_d = 8'd0;
            winner_d   = WIN_NONE;
            lock_cnt_d = '0;
            state_d    = ST_IDLE;
            if (state_q == ST_IDLE) begin
                last_grant_d = PLAYER_2;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        gnt_id_d = arb_id;
                        dec_d    = (arb_id == PLAYER_1) ? p1_dec_i : p2_dec_i;
                        state_d  = ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    stage_d = sat_step(cur_score, dec_q, MAX_S);
                    state_d = ST_UPDATE;
                end
                ST_UPDATE: begin
                    if (gnt_id_q == PLAYER_1) begin
                        p1_score_d = stage_q;
                        p1_ack_d   = 1'b1;
                    end else begin
                        p2_score_d = stage_q;
                        p2_ack_d   = 1'b1;
                    end
                    last_grant_d = gnt_id_q;
                    lock_cnt_d   = '0;
                    if (win_hit) begin
                        winner_d = (gnt_id_q == PLAYER_1) ? WIN_P1 : WIN_P2;
                        state_d  = ST_GAME_OVER;
                    end else begin
                        state_d = ST_LOCKOUT;
                    end
                end
                ST_LOCKOUT: begin
                    if (lock_cnt_q == CNT_LAST) begin
                        lock_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
                ST_GAME_OVER: begin
                    state_d = ST_GAME_OVER;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            p1_score_q   <= 8'd0;
            p2_score_q   <= 8'd0;
            stage_q      <= 8'd0;
            winner_q     <= WIN_NONE;
            last_grant_q <= PLAYER_2;
            gnt_id_q     <= PLAYER_1;
            dec_q        <= 1'b0;
            p1_ack_q     <= 1'b0;
            p2_ack_q     <= 1'b0;
            lock_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            p1_score_q   <= p1_score_d;
            p2_score_q   <= p2_score_d;
            stage_q      <= stage_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            dec_q        <= dec_d;
            p1_ack_q     <= p1_ack_d;
            p2_ack_q     <= p2_ack_d;
            lock_cnt_q   <= lock_cnt_d;
        end
    end

    assign p1_ack_o   = p1_ack_q;
    assign p2_ack_o   = p2_ack_q;
    assign p1_score_o = p1_score_q;
    assign p2_score_o = p2_score_q;
    assign winner_o   = winner_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign state_o    = state_q;

endmodule

// File: tb/tb_score_update_arbiter.sv
// Bench for score_update_arbiter: directed game scenarios plus randomized
// requests/clears, checked cycle by cycle against a score-rule model.
module tb_score_update_arbiter;

    localparam int MAX  = 25;
    localparam int WIN  = 21;
    localparam int LOCK = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       p1_req_i = 1'b0, p1_dec_i = 1'b0;
    logic       p2_req_i = 1'b0, p2_dec_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       p1_ack_o, p2_ack_o, busy_o;
    logic [7:0] p1_score_o, p2_score_o;
    logic [1:0] winner_o;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;
    int n_txn  = 0;

    // Reference model: scores, winner, who was granted last (0 = P1, 1 = P2).
    int m_p1 = 0, m_p2 = 0, m_win = 0, m_last = 1;

    score_update_arbiter #(
        .MAX_SCORE      (MAX),
        .WIN_SCORE      (WIN),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .p1_req_i   (p1_req_i),
        .p1_dec_i   (p1_dec_i),
        .p2_req_i   (p2_req_i),
        .p2_dec_i   (p2_dec_i),
        .clear_i    (clear_i),
        .p1_ack_o   (p1_ack_o),
        .p2_ack_o   (p2_ack_o),
        .p1_score_o (p1_score_o),
        .p2_score_o (p2_score_o),
        .winner_o   (winner_o),
        .busy_o     (busy_o),
        .state_o    (state_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] obs();
        return {8'h0, state_o, p1_ack_o, p2_ack_o, busy_o, winner_o, p1_score_o, p2_score_o};
    endfunction

    function automatic logic [31:0] expv(input int st, input bit a1, input bit a2);
        logic [2:0] s;
        s = 3'(st);
        return {8'h0, s, a1, a2, (st != 0), 2'(m_win), 8'(m_p1), 8'(m_p2)};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (state,a1,a2,busy,win,p1,p2)", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One request episode starting from IDLE; clr_at = edge index at which
    // clear is sampled (0 = never).
    task automatic txn(input bit r1, input bit d1, input bit r2, input bit d2, input int clr_at);
        int g, cur, oth, nv, total, st;
        bit gd, win;
        n_txn++;
        g   = (r1 && r2) ? ((m_last == 0) ? 1 : 0) : (r1 ? 0 : 1);
        gd  = (g == 0) ? d1 : d2;
        cur = (g == 0) ? m_p1 : m_p2;
        oth = (g == 0) ? m_p2 : m_p1;
        if (gd) nv = (cur == 0) ? 0 : cur - 1;
        else    nv = (cur >= MAX) ? MAX : cur + 1;
        win   = (nv == MAX) || (nv >= WIN && nv - oth >= 2);
        total = win ? 3 : 3 + LOCK;
        p1_req_i = r1; p1_dec_i = d1;
        p2_req_i = r2; p2_dec_i = d2;
        for (int e = 1; e <= total; e++) begin
            clear_i = (e == clr_at);
            tick();
            if (e == clr_at) begin
                clear_i = 1'b0; p1_req_i = 1'b0; p2_req_i = 1'b0;
                m_p1 = 0; m_p2 = 0; m_win = 0;
                if (e == 1) m_last = 1;
                check($sformatf("txn%0d_clear_e%0d", n_txn, e), obs(), expv(0, 1'b0, 1'b0));
                $display("txn %0d: req=%0d%0d clear at edge %0d -> p1=%0d p2=%0d", n_txn, r1, r2, e, p1_score_o, p2_score_o);
                return;
            end
            if (e == 3) begin
                if (g == 0) m_p1 = nv; else m_p2 = nv;
                m_last = g;
                if (win) m_win = (g == 0) ? 1 : 2;
            end
            if (e == 1)      st = 1;
            else if (e == 2) st = 2;
            else if (e == 3) st = win ? 4 : 3;
            else             st = (e == total) ? 0 : 3;
            check($sformatf("txn%0d_e%0d", n_txn, e), obs(), expv(st, (e == 3) && (g == 0), (e == 3) && (g == 1)));
            if (e == 3) begin
                if (g == 0) p1_req_i = 1'b0; else p2_req_i = 1'b0;
            end
        end
        p1_req_i = 1'b0; p2_req_i = 1'b0;
        $display("txn %0d: grant=P%0d dec=%0d -> p1=%0d p2=%0d winner=%0d", n_txn, g + 1, gd, p1_score_o, p2_score_o, winner_o);
    endtask

    task automatic do_clear(input string tag);
        int prev_state;
        prev_state = int'(state_o);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        m_p1 = 0; m_p2 = 0; m_win = 0;
        if (prev_state == 0) m_last = 1;
        check(tag, obs(), expv(0, 1'b0, 1'b0));
        $display("clear %s: state=%0d p1=%0d p2=%0d winner=%0d", tag, state_o, p1_score_o, p2_score_o, winner_o);
    endtask

    task automatic over_ignores(input string tag);
        p1_req_i = 1'b1; p2_req_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("%s_%0d", tag, i), obs(), expv(4, 1'b0, 1'b0));
        end
        p1_req_i = 1'b0; p2_req_i = 1'b0;
        $display("game over hold %s: state=%0d winner=%0d", tag, state_o, winner_o);
    endtask

    initial begin
        bit r1, r2, d1, d2;
        int ca;

        // Reset held across edges, then released between edges.
        repeat (3) tick();
        check("reset", obs(), expv(0, 1'b0, 1'b0));
        rst_i = 1'b0;
        tick();
        check("post_reset_idle", obs(), expv(0, 1'b0, 1'b0));

        // Single increment; decrement at zero still acks; first tie goes to P1.
        txn(1, 0, 0, 0, 0);
        txn(0, 0, 1, 1, 0);
        do_clear("clear_idle");
        txn(1, 0, 1, 0, 0);
        txn(1, 0, 1, 0, 0);
        txn(1, 0, 1, 0, 0);

        // Clear during UPDATE and during GRANT / LOCKOUT.
        txn(1, 0, 0, 0, 3);
        txn(0, 0, 1, 0, 2);
        txn(1, 0, 0, 0, 5);
        txn(1, 0, 1, 0, 1);

        // Win with lead: 20/20 -> 21/20 (no win) -> 22/20 (win).
        for (int i = 0; i < 20; i++) begin
            txn(1, 0, 0, 0, 0);
            txn(0, 0, 1, 0, 0);
        end
        txn(1, 0, 0, 0, 0);
        txn(1, 0, 0, 0, 0);
        over_ignores("over_lead");
        do_clear("clear_over_lead");

        // Reaching MAX wins even with a one-point lead.
        for (int i = 0; i < 24; i++) begin
            txn(0, 0, 1, 0, 0);
            txn(1, 0, 0, 0, 0);
        end
        txn(1, 0, 0, 0, 0);
        over_ignores("over_max");
        do_clear("clear_over_max");

        // Randomized play with occasional clears.
        for (int i = 0; i < 60; i++) begin
            r1 = 1'($urandom_range(0, 1));
            r2 = 1'($urandom_range(0, 1));
            if (!r1 && !r2) r1 = 1'b1;
            d1 = ($urandom_range(0, 3) == 0);
            d2 = ($urandom_range(0, 3) == 0);
            ca = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 7)) : 0;
            txn(r1, d1, r2, d2, ca);
            if (m_win != 0) do_clear("clear_rand_over");
        end

        // Asynchronous reset in the middle of LOCKOUT.
        txn(1, 0, 0, 0, 0);
        p1_req_i = 1'b1;
        repeat (4) tick();
        p1_req_i = 1'b0;
        check("pre_async_lockout", 32'(state_o), 32'd3);
        #2;
        rst_i = 1'b1;
        #1;
        m_p1 = 0; m_p2 = 0; m_win = 0; m_last = 1;
        check("async_reset", obs(), expv(0, 1'b0, 1'b0));
        $display("async reset: state=%0d p1=%0d p2=%0d", state_o, p1_score_o, p2_score_o);
        tick();
        rst_i = 1'b0;
        tick();
        check("after_async_reset", obs(), expv(0, 1'b0, 1'b0));
        txn(1, 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
